arb_ddr_sched: RTL and testbench
================================

ARB_DDR_SCHED -- requirements
Module: arb_ddr_sched
Interface
REQ-001 Parameter FIFO_DEPTH, 4, host write FIFO entries (power of 2, 2..16).
REQ-002 Parameter STARVE_LIMIT, 8, consecutive read grants before a pending write is forced (1..255).
REQ-003 CLK133  in  1  sole clock; all logic on its rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 HW_WE_N  in  1  active-low one-cycle host write strobe, one 64-bit word per strobe.
REQ-006 HW_ADDR  in  26  DDR address of host word, sampled with HW_WE_N=0.
REQ-007 HW_DATA  in  64  host write data, sampled with HW_WE_N=0.
REQ-008 DAC_ACT  in  1  playback active; selects read priority.
REQ-009 RD_REQ  in  1  playback read request, level, held until RD_ACK.
REQ-010 RD_ADDR  in  26  playback read address, stable while RD_REQ=1.
REQ-011 RD_ACK  out  1  one-cycle pulse: read request accepted, RD_ADDR latched.
REQ-012 RD_DATA  out  64  read data, valid with RD_VALID.
REQ-013 RD_VALID  out  1  one-cycle read data strobe.
REQ-014 DDR_CMD_VALID  out  1  command to DDR controller valid.
REQ-015 DDR_CMD_WR  out  1  1 = write, 0 = read.
REQ-016 DDR_ADDR  out  26  command address.
REQ-017 DDR_WDATA  out  64  write data, valid with write command.
REQ-018 DDR_CMD_READY  in  1  controller accepts command when high with DDR_CMD_VALID.
REQ-019 DDR_RDATA  in  64  controller read data.
REQ-020 DDR_RVALID  in  1  controller read data strobe.
REQ-021 WR_FULL  out  1  host FIFO full.
REQ-022 WR_OVF  out  1  sticky: host word dropped.
REQ-023 BUSY  out  1  FSM not in IDLE or FIFO non-empty.
Function
REQ-024 FSM states IDLE, WR_CMD, RD_CMD, RD_WAIT; all outputs registered.
REQ-025 Push: HW_WE_N=0 and FIFO not full stores {HW_ADDR,HW_DATA}; fullness evaluated before same-cycle pop, so push while full is dropped and WR_OVF set, even if a pop occurs that cycle.
REQ-026 IDLE arbitration: write candidate = FIFO non-empty; read candidate = RD_REQ=1.
REQ-027 DAC_ACT=1: read wins when both pending; DAC_ACT=0: write wins.
REQ-028 Write grant: IDLE->WR_CMD next cycle with DDR_CMD_VALID=1, DDR_CMD_WR=1, FIFO head on DDR_ADDR/DDR_WDATA.
REQ-029 WR_CMD: outputs held while DDR_CMD_READY=0; on READY=1 FIFO pops, DDR_CMD_VALID drops next cycle, return to IDLE.
REQ-030 Read grant: RD_ACK pulses in the IDLE->RD_CMD transition cycle, RD_ADDR latched; RD_CMD drives DDR_CMD_VALID=1, DDR_CMD_WR=0.
REQ-031 RD_CMD: on DDR_CMD_READY=1 go to RD_WAIT; exactly one read outstanding.
REQ-032 RD_WAIT: on DDR_RVALID=1 register DDR_RDATA to RD_DATA, pulse RD_VALID the following cycle, return to IDLE.
REQ-033 DDR_RVALID outside RD_WAIT is ignored; RD_DATA holds last value.
REQ-034 Minimum command spacing one IDLE cycle; no back-to-back commands.
REQ-035 DAC_ACT changes take effect at the next IDLE arbitration only.
Reset
REQ-036 RESET_N=0 asynchronously: FSM IDLE, FIFO empty, all outputs 0 (WR_FULL=0, WR_OVF=0, RD_DATA=0).
REQ-037 Reset mid-command aborts it; no DDR_CMD_VALID until new arbitration after release; FIFO contents lost.
REQ-038 WR_OVF clears only on reset.
Configuration
REQ-039 Macro ARB_STARVE_GUARD_EN defined: 8-bit counter counts consecutive read grants while FIFO non-empty, clears on any write grant; at STARVE_LIMIT the next arbitration grants write regardless of DAC_ACT.
REQ-040 Macro ARB_STARVE_GUARD_EN undefined: counter absent, pure priority per REQ-027.
Verification
REQ-041 Reset, one host strobe addr 0x0000010 data 0x1122334455667788, READY=1 -> one write cmd with those values, FIFO empty, BUSY=0.
REQ-042 DAC_ACT=1, RD_REQ and 1 queued write together -> read command first (RD_ACK, RD_VALID after RVALID), then write.
REQ-043 READY=0, 5 host strobes, FIFO_DEPTH=4 -> WR_FULL=1, WR_OVF=1, after READY=1 exactly 4 writes in push order.
REQ-044 ARB_STARVE_GUARD_EN, DAC_ACT=1, RD_REQ held, 1 queued write -> write issued after 8 reads; without macro write never issued while RD_REQ=1.
REQ-045 RESET_N low during RD_WAIT, then RVALID after release -> no RD_VALID, outputs zero.

Source files
------------

// File: rtl/arb_ddr_sched_if.sv
// Host-write, playback-read and DDR command signals for arb_ddr_sched.
// The slave modport is the scheduler's view; master is the surrounding system's.
interface arb_ddr_sched_if;
    logic        HW_WE_N;
    logic [25:0] HW_ADDR;
    logic [63:0] HW_DATA;
    logic        DAC_ACT;
    logic        RD_REQ;
    logic [25:0] RD_ADDR;
    logic        RD_ACK;
    logic [63:0] RD_DATA;
    logic        RD_VALID;
    logic        DDR_CMD_VALID;
    logic        DDR_CMD_WR;
    logic [25:0] DDR_ADDR;
    logic [63:0] DDR_WDATA;
    logic        DDR_CMD_READY;
    logic [63:0] DDR_RDATA;
    logic        DDR_RVALID;
    logic        WR_FULL;
    logic        WR_OVF;
    logic        BUSY;

    modport slave (
        input  HW_WE_N, HW_ADDR, HW_DATA, DAC_ACT, RD_REQ, RD_ADDR,
               DDR_CMD_READY, DDR_RDATA, DDR_RVALID,
        output RD_ACK, RD_DATA, RD_VALID, DDR_CMD_VALID, DDR_CMD_WR, DDR_ADDR, DDR_WDATA,
               WR_FULL, WR_OVF, BUSY
    );

    modport master (
        output HW_WE_N, HW_ADDR, HW_DATA, DAC_ACT, RD_REQ, RD_ADDR,
               DDR_CMD_READY, DDR_RDATA, DDR_RVALID,
        input  RD_ACK, RD_DATA, RD_VALID, DDR_CMD_VALID, DDR_CMD_WR, DDR_ADDR, DDR_WDATA,
               WR_FULL, WR_OVF, BUSY
    );
endinterface

// File: rtl/arb_ddr_sched.sv
// DDR command scheduler: host write FIFO vs. playback reads, one command in flight.
// Define ARB_STARVE_GUARD_EN to force a queued write after STARVE_LIMIT consecutive reads.
module arb_ddr_sched #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic            CLK133,
    input logic            RESET_N,
    arb_ddr_sched_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : gen_bad_param
        $error("arb_ddr_sched: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StWrCmd, StRdCmd, StRdWait} state_e;

    state_e          state_q;
    logic [89:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            wr_ovf_q;
    logic            cmd_valid_q, cmd_wr_q, rd_ack_q, rd_valid_q;
    logic [25:0]     ddr_addr_q;
    logic [63:0]     ddr_wdata_q, rd_data_q;

    logic        fifo_full, fifo_empty, push, pop;
    logic        wr_cand, rd_cand, grant_wr, grant_rd;
    logic [89:0] head;

    assign fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    // Fullness is judged before any same-cycle pop, so a strobe while full is always lost.
    assign push = !bus.HW_WE_N && !fifo_full;
    assign pop  = (state_q == StWrCmd) && bus.DDR_CMD_READY;
    assign head = mem_q[rd_ptr_q];

    assign wr_cand = !fifo_empty;
    assign rd_cand = bus.RD_REQ;

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] starve_q;
    logic       starve_force;

    assign starve_force = (starve_q >= 8'(STARVE_LIMIT));
    assign grant_wr     = wr_cand && (!rd_cand || !bus.DAC_ACT || starve_force);

    always_ff @(posedge CLK133 or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_q <= '0;
        end else if (state_q == StIdle) begin
            if (grant_wr) begin
                starve_q <= '0;
            end else if (grant_rd) begin
                if (!wr_cand) begin
                    starve_q <= '0;
                end else if (starve_q != 8'hff) begin
                    starve_q <= starve_q + 8'd1;
                end
            end
        end
    end
`else
    assign grant_wr = wr_cand && (!rd_cand || !bus.DAC_ACT);
`endif
    assign grant_rd = rd_cand && !grant_wr;

    // Storage is not reset; occupancy and pointers define what is valid.
    always_ff @(posedge CLK133) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.HW_ADDR, bus.HW_DATA};
        end
    end

    always_ff @(posedge CLK133 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wr_ovf_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (!bus.HW_WE_N && fifo_full) wr_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK133 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            ddr_addr_q  <= '0;
            ddr_wdata_q <= '0;
            rd_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_wr) begin
                        state_q     <= StWrCmd;
                        cmd_valid_q <= 1'b1;
                        cmd_wr_q    <= 1'b1;
                        ddr_addr_q  <= head[89:64];
                        ddr_wdata_q <= head[63:0];
                    end else if (grant_rd) begin
                        state_q     <= StRdCmd;
                        cmd_valid_q <= 1'b1;
                        cmd_wr_q    <= 1'b0;
                        ddr_addr_q  <= bus.RD_ADDR;
                        rd_ack_q    <= 1'b1;
                    end
                end
                StWrCmd: begin
                    if (bus.DDR_CMD_READY) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StRdCmd: begin
                    if (bus.DDR_CMD_READY) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (bus.DDR_RVALID) begin
                        rd_data_q  <= bus.DDR_RDATA;
                        rd_valid_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.DDR_CMD_VALID = cmd_valid_q;
    assign bus.DDR_CMD_WR    = cmd_wr_q;
    assign bus.DDR_ADDR      = ddr_addr_q;
    assign bus.DDR_WDATA     = ddr_wdata_q;
    assign bus.RD_ACK        = rd_ack_q;
    assign bus.RD_VALID      = rd_valid_q;
    assign bus.RD_DATA       = rd_data_q;
    assign bus.WR_FULL       = fifo_full;
    assign bus.WR_OVF        = wr_ovf_q;
    assign bus.BUSY          = (state_q != StIdle) || !fifo_empty;
endmodule

// File: tb/tb_arb_ddr_sched.sv
// Randomized bench for arb_ddr_sched against a transaction-level scheduler model.
// The model tracks the queued writes, the command on the DDR port and the pending read.
module tb_arb_ddr_sched;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic CLK133;
    logic RESET_N;

    arb_ddr_sched_if bus ();

    arb_ddr_sched #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK133 (CLK133),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    initial CLK133 = 1'b0;
    always #5 CLK133 = ~CLK133;

    int n_total = 0;
    int n_bad   = 0;

    // Model state
    logic [89:0] q[$];
    bit          m_cmd_on, m_cmd_wr, m_rd_wait, m_ack, m_rvalid, m_ovf;
    logic [25:0] m_cmd_addr;
    logic [63:0] m_cmd_data, m_rdata;
    int unsigned m_starve;

    // Stimulus knobs
    int unsigned p_we, p_req, p_ready, p_rvalid, dac_mode;
    bit          ow_we, force_rvalid, req_on, hit;
    logic [25:0] ow_addr;
    logic [63:0] ow_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("cmd_valid", 64'(bus.DDR_CMD_VALID), 64'(m_cmd_on));
        if (m_cmd_on) begin
            check_eq("cmd_wr", 64'(bus.DDR_CMD_WR), 64'(m_cmd_wr));
            check_eq("cmd_addr", 64'(bus.DDR_ADDR), 64'(m_cmd_addr));
            if (m_cmd_wr) check_eq("cmd_wdata", bus.DDR_WDATA, m_cmd_data);
        end
        check_eq("rd_ack", 64'(bus.RD_ACK), 64'(m_ack));
        check_eq("rd_valid", 64'(bus.RD_VALID), 64'(m_rvalid));
        check_eq("rd_data", bus.RD_DATA, m_rdata);
        check_eq("wr_full", 64'(bus.WR_FULL), 64'(q.size() == DEPTH));
        check_eq("wr_ovf", 64'(bus.WR_OVF), 64'(m_ovf));
        check_eq("busy", 64'(bus.BUSY), 64'(m_cmd_on || m_rd_wait || q.size() != 0));
    endtask

    // Drive inputs for the coming rising edge and advance the model across that edge.
    task automatic drive_and_model();
        logic [25:0] a;
        logic [63:0] d, rd;
        bit          we, rdy, rv, full_before, frc;
        a  = 26'($urandom);
        d  = {$urandom, $urandom};
        we = 1'b0;
        if (ow_we) begin
            we = 1'b1; a = ow_addr; d = ow_data; ow_we = 1'b0;
        end else if ($urandom_range(99) < p_we) begin
            we = 1'b1;
        end
        bus.HW_WE_N = !we;
        bus.HW_ADDR = a;
        bus.HW_DATA = d;
        if (bus.RD_ACK) begin
            req_on = 1'b0;
        end else if (!req_on && $urandom_range(99) < p_req) begin
            req_on = 1'b1;
            bus.RD_ADDR = 26'($urandom);
        end
        bus.RD_REQ = req_on;
        case (dac_mode)
            0: bus.DAC_ACT = 1'b0;
            1: bus.DAC_ACT = 1'b1;
            default: if ($urandom_range(9) == 0) bus.DAC_ACT = !bus.DAC_ACT;
        endcase
        rdy = ($urandom_range(99) < p_ready);
        rv  = force_rvalid || ($urandom_range(99) < p_rvalid);
        force_rvalid = 1'b0;
        rd  = {$urandom, $urandom};
        bus.DDR_CMD_READY = rdy;
        bus.DDR_RVALID    = rv;
        bus.DDR_RDATA     = rd;

        full_before = (q.size() == DEPTH);
        m_ack    = 1'b0;
        m_rvalid = 1'b0;
        if (m_cmd_on) begin
            if (rdy) begin
                m_cmd_on = 1'b0;
                if (m_cmd_wr) void'(q.pop_front());
                else m_rd_wait = 1'b1;
            end
        end else if (m_rd_wait) begin
            if (rv) begin
                m_rd_wait = 1'b0;
                m_rvalid  = 1'b1;
                m_rdata   = rd;
            end
        end else begin
            frc = Guard && (m_starve >= LIMIT);
            if (q.size() != 0 && (!req_on || !bus.DAC_ACT || frc)) begin
                m_cmd_on = 1'b1;
                m_cmd_wr = 1'b1;
                {m_cmd_addr, m_cmd_data} = q[0];
                m_starve = 0;
            end else if (req_on) begin
                m_cmd_on   = 1'b1;
                m_cmd_wr   = 1'b0;
                m_cmd_addr = bus.RD_ADDR;
                m_ack      = 1'b1;
                if (q.size() == 0) m_starve = 0;
                else if (m_starve < 255) m_starve = m_starve + 1;
            end
        end
        if (we) begin
            if (full_before) m_ovf = 1'b1;
            else q.push_back({a, d});
        end
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        bus.HW_WE_N = 1'b1;
        bus.RD_REQ = 1'b0;
        req_on = 1'b0;
        bus.DDR_CMD_READY = 1'b0;
        bus.DDR_RVALID = 1'b0;
        #1;
        check_eq("rst_cmd_valid", 64'(bus.DDR_CMD_VALID), 64'd0);
        check_eq("rst_cmd_wr", 64'(bus.DDR_CMD_WR), 64'd0);
        check_eq("rst_addr", 64'(bus.DDR_ADDR), 64'd0);
        check_eq("rst_wdata", bus.DDR_WDATA, 64'd0);
        check_eq("rst_rd_ack", 64'(bus.RD_ACK), 64'd0);
        check_eq("rst_rd_valid", 64'(bus.RD_VALID), 64'd0);
        check_eq("rst_rd_data", bus.RD_DATA, 64'd0);
        check_eq("rst_wr_full", 64'(bus.WR_FULL), 64'd0);
        check_eq("rst_wr_ovf", 64'(bus.WR_OVF), 64'd0);
        check_eq("rst_busy", 64'(bus.BUSY), 64'd0);
        q.delete();
        m_cmd_on = 1'b0; m_cmd_wr = 1'b0; m_rd_wait = 1'b0; m_ack = 1'b0;
        m_rvalid = 1'b0; m_ovf = 1'b0; m_rdata = '0; m_starve = 0;
        @(negedge CLK133);
        @(negedge CLK133);
        RESET_N = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge CLK133);
            check_outputs();
            drive_and_model();
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        bus.HW_WE_N = 1'b1; bus.HW_ADDR = '0; bus.HW_DATA = '0; bus.DAC_ACT = 1'b0;
        bus.RD_REQ = 1'b0; bus.RD_ADDR = '0;
        bus.DDR_CMD_READY = 1'b0; bus.DDR_RDATA = '0; bus.DDR_RVALID = 1'b0;
        force_rvalid = 1'b0; req_on = 1'b0; hit = 1'b0;

        // Single host word straight through to DDR
        p_we = 0; p_req = 0; p_ready = 100; p_rvalid = 0; dac_mode = 0;
        ow_we = 1'b1; ow_addr = 26'h0000010; ow_data = 64'h1122334455667788;
        @(negedge CLK133);
        do_reset();
        drive_and_model();
        run(8);

        // Read and queued write both pending with playback active: read first
        dac_mode = 1; p_rvalid = 50;
        ow_we = 1'b1; ow_addr = 26'($urandom); ow_data = {$urandom, $urandom};
        run(1);
        p_req = 100;
        run(1);
        p_req = 0;
        run(20);

        // Controller stalled, five strobes into a four-deep FIFO
        dac_mode = 0; p_ready = 0; p_we = 100;
        run(5);
        p_we = 0;
        run(3);
        p_ready = 100;
        run(20);

        // Randomized traffic
        for (int k = 0; k < 6; k++) begin
            p_we = $urandom_range(60, 10); p_req = $urandom_range(80, 10);
            p_ready = $urandom_range(100, 20); p_rvalid = $urandom_range(100, 10);
            dac_mode = 2;
            run(250);
        end

        // Read request held continuously against one queued write
        @(negedge CLK133);
        do_reset();
        dac_mode = 1; p_req = 100; p_ready = 100; p_rvalid = 100; p_we = 0;
        ow_we = 1'b1; ow_addr = 26'($urandom); ow_data = {$urandom, $urandom};
        drive_and_model();
        run(60);
        p_req = 0;
        run(12);

        // Reset while a read is outstanding, then a late RVALID
        dac_mode = 0; p_we = 0; p_req = 100; p_ready = 100; p_rvalid = 0;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge CLK133);
            check_outputs();
            if (m_rd_wait) hit = 1'b1;
            else drive_and_model();
        end
        if (!hit) check_eq("rd_wait_timeout", 64'(m_rd_wait), 64'd1);
        else check_eq("rd_wait_busy", 64'(bus.BUSY), 64'd1);
        p_req = 0;
        do_reset();
        force_rvalid = 1'b1;
        drive_and_model();
        run(10);

        // More randomized traffic after the reset
        p_we = 30; p_req = 40; p_ready = 70; p_rvalid = 50; dac_mode = 2;
        run(500);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
